opx_bundle_mux: RTL and testbench

//  Parametrised successor to the per-group control-signal multiplexer in the ForthCPU decode path.
//  - Selects one of NUM_GROUPS packed control bundles by the instruction group field.
//  - Latches the selection at DECODE and holds it stable through EXECUTE/COMMIT.
//  - Registers ADDR_BUSX per phase.
//  - Tracks the FETCH->DECODE->EXECUTE->COMMIT phase order, with STALL support.

---
 rtl/opx_bundle_mux_pkg.sv | 50 +++++
 rtl/opx_bundle_mux_phase_tracker.sv | 68 ++++++
 rtl/opx_bundle_mux.sv | 133 +++++++++++++
 tb/tb_opx_bundle_mux.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/opx_bundle_mux_pkg.sv
// opx_bundle_mux_pkg
//   Constants and helpers shared by the decode-path control-bundle mux and
//   the group units that produce the bundles.
//   - phase_e       : phase tracker state codes (PH_IDLE..PH_C, 3 bits)
//   - ADDR_BUSX_*   : address-bus select codes
//   - GROUP_*       : instruction group codes (INSTRUCTION[15:14] by default)
//   - BF_*          : bundle field offsets/widths, so producers and decode
//                     agree on how ALU_OPX..WRX are packed
//   - strobe_pri()  : phase strobe priority FETCH > DECODE > EXECUTE > COMMIT
package opx_bundle_mux_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_F    = 3'd1,
    PH_D    = 3'd2,
    PH_E    = 3'd3,
    PH_C    = 3'd4
  } phase_e;

  localparam int unsigned ADDR_BUSX_PC_A = 0;

  localparam int unsigned GROUP_0 = 0;
  localparam int unsigned GROUP_1 = 1;
  localparam int unsigned GROUP_2 = 2;
  localparam int unsigned GROUP_3 = 3;

  // Bundle packing, LSB first.
  localparam int unsigned BF_ALU_OPX_LSB  = 0;
  localparam int unsigned BF_ALU_OPX_W    = 8;
  localparam int unsigned BF_ADDR_OPX_LSB = 8;
  localparam int unsigned BF_ADDR_OPX_W   = 8;
  localparam int unsigned BF_CC_OPX_LSB   = 16;
  localparam int unsigned BF_CC_OPX_W     = 8;
  localparam int unsigned BF_WRX_LSB      = 24;
  localparam int unsigned BF_WRX_W        = 8;

  // Highest-priority strobe this cycle, expressed as the phase it leads to.
  // PH_IDLE means no strobe.
  function automatic phase_e strobe_pri(input logic f, input logic d,
                                        input logic e, input logic c);
    phase_e r;
    r = PH_IDLE;
    if (c) r = PH_C;
    if (e) r = PH_E;
    if (d) r = PH_D;
    if (f) r = PH_F;
    return r;
  endfunction

endpackage

// File: rtl/opx_bundle_mux_phase_tracker.sv
// opx_phase_tracker
//   FETCH->DECODE->EXECUTE->COMMIT phase tracker. The tracker always follows
//   the highest-priority strobe; with OPX_PHASE_CHECK_EN defined it also
//   raises a sticky PHASE_ERR on any strobe that breaks the expected order.
// Ports
//   CLK, RESET      clock, synchronous active-high reset
//   STALL           freeze: strobes this cycle are dropped
//   FETCH..COMMIT   phase strobes
//   STATE           current tracker state
//   PHASE_ERR       sticky order error (tied 0 without OPX_PHASE_CHECK_EN)
// Build option: `OPX_PHASE_CHECK_EN
module opx_phase_tracker
  import opx_bundle_mux_pkg::*;
(
  input  logic   CLK,
  input  logic   RESET,
  input  logic   STALL,
  input  logic   FETCH,
  input  logic   DECODE,
  input  logic   EXECUTE,
  input  logic   COMMIT,
  output phase_e STATE,
  output logic   PHASE_ERR
);

  phase_e r_state;
  phase_e w_next;
  phase_e w_strobe;

  always_ff @(posedge CLK) begin
    if (RESET)       r_state <= PH_IDLE;
    else if (!STALL) r_state <= w_next;
  end

  always_comb begin
    w_strobe = strobe_pri(FETCH, DECODE, EXECUTE, COMMIT);
    w_next   = r_state;
    if (w_strobe != PH_IDLE) w_next = w_strobe;
  end

  assign STATE = r_state;

`ifdef OPX_PHASE_CHECK_EN
  logic w_order_ok;
  logic r_err;

  always_comb begin
    w_order_ok = 1'b1;
    case (w_strobe)
      PH_F:    w_order_ok = (r_state == PH_IDLE) || (r_state == PH_C);
      PH_D:    w_order_ok = (r_state == PH_F);
      PH_E:    w_order_ok = (r_state == PH_D);
      PH_C:    w_order_ok = (r_state == PH_E);
      default: w_order_ok = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET)                    r_err <= 1'b0;
    else if (!STALL && !w_order_ok) r_err <= 1'b1;
  end

  assign PHASE_ERR = r_err;
`else
  assign PHASE_ERR = 1'b0;
`endif

endmodule

// File: rtl/opx_bundle_mux.sv
// opx_bundle_mux
//   Selects one of NUM_GROUPS packed control bundles by the instruction group
//   field, latches the choice at DECODE and holds the group through
//   EXECUTE/COMMIT. ADDR_BUSX is registered per phase.
// Ports
//   CLK, RESET        clock, synchronous active-high reset (wins over STALL)
//   INSTRUCTION       instruction word; group = INSTRUCTION[15 -: GROUP_W]
//   FETCH..COMMIT     phase strobes (priority F > D > E > C)
//   STALL             freeze all state this cycle, strobes dropped
//   SRC_BUNDLE        group g bundle at [g*BUNDLE_W +: BUNDLE_W]
//   SRC_VALID         group g drives its bundle (else DEFAULT_BUNDLE)
//   SRC_ADDR_BUSX     group g address-bus select, used at EXECUTE
//   BUNDLE            registered selected bundle
//   BUNDLE_VALID      BUNDLE belongs to the instruction in flight
//   GROUP             latched group index
//   ADDR_BUSX         registered address-bus select
//   PHASE_ERR         sticky phase-order error
// Build option: `OPX_PHASE_CHECK_EN enables phase-order checking.
module opx_bundle_mux
  import opx_bundle_mux_pkg::*;
#(
  parameter int                   NUM_GROUPS     = 4,
  parameter int                   GROUP_W        = 2,
  parameter int                   BUNDLE_W       = 32,
  parameter int                   ADDRX_W        = 2,
  parameter logic [BUNDLE_W-1:0]  DEFAULT_BUNDLE = '0
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [15:0]                    INSTRUCTION,
  input  logic                           FETCH,
  input  logic                           DECODE,
  input  logic                           EXECUTE,
  input  logic                           COMMIT,
  input  logic                           STALL,
  input  logic [NUM_GROUPS*BUNDLE_W-1:0] SRC_BUNDLE,
  input  logic [NUM_GROUPS-1:0]          SRC_VALID,
  input  logic [NUM_GROUPS*ADDRX_W-1:0]  SRC_ADDR_BUSX,
  output logic [BUNDLE_W-1:0]            BUNDLE,
  output logic                           BUNDLE_VALID,
  output logic [GROUP_W-1:0]             GROUP,
  output logic [ADDRX_W-1:0]             ADDR_BUSX,
  output logic                           PHASE_ERR
);

  // Every encodable group gets a slot; unpopulated slots read as default so
  // the mux can be indexed directly by the group field.
  localparam int NSLOT = 2 ** GROUP_W;
  localparam logic [ADDRX_W-1:0] PC_A = ADDRX_W'(ADDR_BUSX_PC_A);

  logic [NSLOT-1:0][BUNDLE_W-1:0] w_slot_bundle;
  logic [NSLOT-1:0][ADDRX_W-1:0]  w_slot_addr;
  logic [GROUP_W-1:0]             w_dec_group;
  logic                           w_unused_instr;
  phase_e                         w_strobe;
  phase_e                         w_state;

  logic [BUNDLE_W-1:0] r_bundle;
  logic                r_valid;
  logic [GROUP_W-1:0]  r_group;
  logic [ADDRX_W-1:0]  r_addrx;

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NUM_GROUPS) begin : g_pop
      assign w_slot_bundle[g] = SRC_VALID[g] ? SRC_BUNDLE[g*BUNDLE_W +: BUNDLE_W]
                                             : DEFAULT_BUNDLE;
      assign w_slot_addr[g]   = SRC_VALID[g] ? SRC_ADDR_BUSX[g*ADDRX_W +: ADDRX_W]
                                             : PC_A;
    end else begin : g_unpop
      assign w_slot_bundle[g] = DEFAULT_BUNDLE;
      assign w_slot_addr[g]   = PC_A;
    end
  end

  assign w_dec_group    = INSTRUCTION[15 -: GROUP_W];
  assign w_unused_instr = ^INSTRUCTION[15-GROUP_W:0];
  assign w_strobe       = strobe_pri(FETCH, DECODE, EXECUTE, COMMIT);

  opx_phase_tracker u_trk (
    .CLK       (CLK),
    .RESET     (RESET),
    .STALL     (STALL),
    .FETCH     (FETCH),
    .DECODE    (DECODE),
    .EXECUTE   (EXECUTE),
    .COMMIT    (COMMIT),
    .STATE     (w_state),
    .PHASE_ERR (PHASE_ERR)
  );

  // Actions follow the winning strobe, not the tracker state, so an
  // out-of-order strobe still does its work.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bundle <= DEFAULT_BUNDLE;
      r_valid  <= 1'b0;
      r_group  <= '0;
      r_addrx  <= PC_A;
    end else if (!STALL) begin
      case (w_strobe)
        PH_F: begin
          r_bundle <= DEFAULT_BUNDLE;
          r_valid  <= 1'b0;
          r_addrx  <= PC_A;
        end
        PH_D: begin
          r_group  <= w_dec_group;
          r_bundle <= w_slot_bundle[w_dec_group];
          r_valid  <= 1'b1;
        end
        PH_E: begin
          r_bundle <= w_slot_bundle[r_group];
          r_addrx  <= w_slot_addr[r_group];
        end
        PH_C: begin
          r_valid  <= 1'b0;
        end
        default: begin
          // Holding in E/C: follow the latched group's unit, which may be
          // sequencing a multi-cycle op.
          if (w_state == PH_E || w_state == PH_C)
            r_bundle <= w_slot_bundle[r_group];
        end
      endcase
    end
  end

  assign BUNDLE       = r_bundle;
  assign BUNDLE_VALID = r_valid;
  assign GROUP        = r_group;
  assign ADDR_BUSX    = r_addrx;

endmodule

// File: tb/tb_opx_bundle_mux.sv
module tb_opx_bundle_mux;
  import opx_bundle_mux_pkg::*;

  localparam int NG = 4;
  localparam int GW = 2;
  localparam int BW = 32;
  localparam int AW = 2;
  localparam logic [BW-1:0] DEF = 32'h0;
  localparam logic [AW-1:0] PCA = AW'(ADDR_BUSX_PC_A);
`ifdef OPX_PHASE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET, FETCH, DECODE, EXECUTE, COMMIT, STALL;
  logic [15:0]        INSTRUCTION;
  logic [BW-1:0]      src_b [NG];
  logic [AW-1:0]      src_a [NG];
  logic [NG-1:0]      SRC_VALID;
  logic [NG*BW-1:0]   SRC_BUNDLE;
  logic [NG*AW-1:0]   SRC_ADDR_BUSX;
  logic [BW-1:0]      BUNDLE;
  logic               BUNDLE_VALID;
  logic [GW-1:0]      GROUP;
  logic [AW-1:0]      ADDR_BUSX;
  logic               PHASE_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int            m_ph;
  logic [GW-1:0] m_group;
  logic [BW-1:0] m_bundle;
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic          m_err;

  always #5 CLK = ~CLK;

  always_comb begin
    SRC_BUNDLE    = '0;
    SRC_ADDR_BUSX = '0;
    for (int g = 0; g < NG; g++) begin
      SRC_BUNDLE[g*BW +: BW]    = src_b[g];
      SRC_ADDR_BUSX[g*AW +: AW] = src_a[g];
    end
  end

  opx_bundle_mux #(
    .NUM_GROUPS(NG), .GROUP_W(GW), .BUNDLE_W(BW), .ADDRX_W(AW), .DEFAULT_BUNDLE(DEF)
  ) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
    .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE), .COMMIT(COMMIT),
    .STALL(STALL), .SRC_BUNDLE(SRC_BUNDLE), .SRC_VALID(SRC_VALID),
    .SRC_ADDR_BUSX(SRC_ADDR_BUSX), .BUNDLE(BUNDLE), .BUNDLE_VALID(BUNDLE_VALID),
    .GROUP(GROUP), .ADDR_BUSX(ADDR_BUSX), .PHASE_ERR(PHASE_ERR)
  );

  // one clock with strobes {F,D,E,C}; outputs sampled 1ns after the edge
  task automatic cyc(input logic [3:0] s);
    {FETCH, DECODE, EXECUTE, COMMIT} = s;
    @(posedge CLK); #1;
    {FETCH, DECODE, EXECUTE, COMMIT} = 4'b0;
  endtask

  task automatic set_default_src();
    for (int g = 0; g < NG; g++) begin
      src_b[g] = 32'hA0 + g;
      src_a[g] = AW'(g);
    end
    SRC_VALID = 4'b1111;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cyc(4'b0000);
    cyc(4'b0000);
    RESET = 1'b0;
    n_tests++; if (BUNDLE !== DEF) begin n_fail++; $display("FAIL rst_bundle got %h want %h", BUNDLE, DEF); end
    n_tests++; if (BUNDLE_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", BUNDLE_VALID); end
    n_tests++; if (GROUP !== 2'd0) begin n_fail++; $display("FAIL rst_group got %0d want 0", GROUP); end
    n_tests++; if (ADDR_BUSX !== PCA) begin n_fail++; $display("FAIL rst_addrx got %0d want %0d", ADDR_BUSX, PCA); end
    n_tests++; if (PHASE_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", PHASE_ERR); end
  endtask

  task automatic test_reset_mid_execute();
    INSTRUCTION = 16'hC000;
    cyc(4'b1000); cyc(4'b0100); cyc(4'b0010);
    n_tests++; if (ADDR_BUSX !== 2'd3) begin n_fail++; $display("FAIL pre_rst_addrx got %0d want 3", ADDR_BUSX); end
    n_tests++; if (BUNDLE !== 32'hA3) begin n_fail++; $display("FAIL pre_rst_bundle got %h want a3", BUNDLE); end
    RESET = 1'b1; STALL = 1'b1;
    cyc(4'b0001);
    RESET = 1'b0; STALL = 1'b0;
    n_tests++; if (BUNDLE !== DEF) begin n_fail++; $display("FAIL midrst_bundle got %h want %h", BUNDLE, DEF); end
    n_tests++; if (BUNDLE_VALID !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", BUNDLE_VALID); end
    n_tests++; if (ADDR_BUSX !== PCA) begin n_fail++; $display("FAIL midrst_addrx got %0d want %0d", ADDR_BUSX, PCA); end
    n_tests++; if (GROUP !== 2'd0) begin n_fail++; $display("FAIL midrst_group got %0d want 0", GROUP); end
  endtask

  task automatic test_sequence();
    INSTRUCTION = 16'h8000;
    cyc(4'b1000);
    cyc(4'b0100);
    n_tests++; if (BUNDLE !== 32'hA2) begin n_fail++; $display("FAIL seq_d_bundle got %h want a2", BUNDLE); end
    n_tests++; if (BUNDLE_VALID !== 1'b1) begin n_fail++; $display("FAIL seq_d_valid got %b want 1", BUNDLE_VALID); end
    n_tests++; if (GROUP !== 2'd2) begin n_fail++; $display("FAIL seq_d_group got %0d want 2", GROUP); end
    cyc(4'b0010);
    n_tests++; if (ADDR_BUSX !== 2'd2) begin n_fail++; $display("FAIL seq_e_addrx got %0d want 2", ADDR_BUSX); end
    // instruction changes while E is held
    INSTRUCTION = 16'h4000;
    cyc(4'b0000); cyc(4'b0000);
    n_tests++; if (BUNDLE !== 32'hA2) begin n_fail++; $display("FAIL hold_bundle got %h want a2", BUNDLE); end
    n_tests++; if (GROUP !== 2'd2) begin n_fail++; $display("FAIL hold_group got %0d want 2", GROUP); end
    cyc(4'b0001);
    n_tests++; if (BUNDLE_VALID !== 1'b0) begin n_fail++; $display("FAIL seq_c_valid got %b want 0", BUNDLE_VALID); end
    n_tests++; if (BUNDLE !== 32'hA2) begin n_fail++; $display("FAIL seq_c_bundle got %h want a2", BUNDLE); end
  endtask

  task automatic test_invalid_group();
    SRC_VALID = 4'b1101;
    INSTRUCTION = 16'h4000;
    cyc(4'b1000);
    cyc(4'b0100);
    n_tests++; if (BUNDLE !== DEF) begin n_fail++; $display("FAIL inv_bundle got %h want %h", BUNDLE, DEF); end
    n_tests++; if (GROUP !== 2'd1) begin n_fail++; $display("FAIL inv_group got %0d want 1", GROUP); end
    cyc(4'b0010);
    n_tests++; if (ADDR_BUSX !== PCA) begin n_fail++; $display("FAIL inv_addrx got %0d want %0d", ADDR_BUSX, PCA); end
    cyc(4'b0001);
    SRC_VALID = 4'b1111;
  endtask

  task automatic test_stall();
    INSTRUCTION = 16'h8000;
    cyc(4'b1000);
    STALL = 1'b1;
    cyc(4'b0100);
    STALL = 1'b0;
    n_tests++; if (BUNDLE !== DEF) begin n_fail++; $display("FAIL stall_bundle got %h want %h", BUNDLE, DEF); end
    n_tests++; if (BUNDLE_VALID !== 1'b0) begin n_fail++; $display("FAIL stall_valid got %b want 0", BUNDLE_VALID); end
    n_tests++; if (GROUP !== 2'd1) begin n_fail++; $display("FAIL stall_group got %0d want 1", GROUP); end
    cyc(4'b0100);
    n_tests++; if (BUNDLE !== 32'hA2) begin n_fail++; $display("FAIL unstall_bundle got %h want a2", BUNDLE); end
    n_tests++; if (BUNDLE_VALID !== 1'b1) begin n_fail++; $display("FAIL unstall_valid got %b want 1", BUNDLE_VALID); end
    cyc(4'b0010);
    cyc(4'b0001);
  endtask

  task automatic test_fetch_priority();
    // tracker in C, ADDR_BUSX=2, group 2
    cyc(4'b1010);
    n_tests++; if (ADDR_BUSX !== PCA) begin n_fail++; $display("FAIL fe_addrx got %0d want %0d", ADDR_BUSX, PCA); end
    n_tests++; if (BUNDLE !== DEF) begin n_fail++; $display("FAIL fe_bundle got %h want %h", BUNDLE, DEF); end
    n_tests++; if (PHASE_ERR !== 1'b0) begin n_fail++; $display("FAIL fe_err got %b want 0", PHASE_ERR); end
    cyc(4'b0010); // EXECUTE straight after FETCH
    n_tests++; if (PHASE_ERR !== CHK) begin n_fail++; $display("FAIL ooo_err got %b want %b", PHASE_ERR, CHK); end
    n_tests++; if (ADDR_BUSX !== 2'd2) begin n_fail++; $display("FAIL ooo_addrx got %0d want 2", ADDR_BUSX); end
    cyc(4'b1000);
    n_tests++; if (PHASE_ERR !== CHK) begin n_fail++; $display("FAIL sticky_err got %b want %b", PHASE_ERR, CHK); end
    RESET = 1'b1;
    cyc(4'b0000);
    RESET = 1'b0;
    n_tests++; if (PHASE_ERR !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b want 0", PHASE_ERR); end
  endtask

  function automatic logic [BW-1:0] pick(input logic [GW-1:0] g);
    return SRC_VALID[g] ? src_b[g] : DEF;
  endfunction

  // Next-state of the observable behaviour, from the current inputs.
  task automatic model_step();
    int s;
    bit legal;
    if (RESET) begin
      m_ph = 0; m_group = '0; m_bundle = DEF; m_valid = 1'b0; m_addr = PCA; m_err = 1'b0;
    end else if (!STALL) begin
      s = FETCH ? 1 : DECODE ? 2 : EXECUTE ? 3 : COMMIT ? 4 : 0;
      legal = (s == 0) || (s == 1 && (m_ph == 0 || m_ph == 4)) || (s > 1 && m_ph == s - 1);
      if (CHK && !legal) m_err = 1'b1;
      case (s)
        1: begin m_bundle = DEF; m_valid = 1'b0; m_addr = PCA; end
        2: begin m_group = INSTRUCTION[15:14]; m_bundle = pick(m_group); m_valid = 1'b1; end
        3: begin m_bundle = pick(m_group); m_addr = SRC_VALID[m_group] ? src_a[m_group] : PCA; end
        4: m_valid = 1'b0;
        default: if (m_ph == 3 || m_ph == 4) m_bundle = pick(m_group);
      endcase
      if (s != 0) m_ph = s;
    end
  endtask

  task automatic test_random();
    int r, nxt;
    RESET = 1'b1;
    model_step();
    cyc(4'b0000);
    RESET = 1'b0;
    for (int i = 0; i < 800; i++) begin
      RESET = ($urandom_range(0, 99) < 2);
      STALL = ($urandom_range(0, 99) < 10);
      INSTRUCTION = 16'($urandom);
      if ($urandom_range(0, 99) < 15) src_b[$urandom_range(0, NG-1)] = $urandom;
      if ($urandom_range(0, 99) < 10) src_a[$urandom_range(0, NG-1)] = AW'($urandom);
      if ($urandom_range(0, 99) < 10) SRC_VALID = NG'($urandom);
      r = $urandom_range(0, 99);
      nxt = (m_ph == 0 || m_ph == 4) ? 1 : m_ph + 1;
      if (r < 65)      {FETCH, DECODE, EXECUTE, COMMIT} = 4'b1000 >> (nxt - 1);
      else if (r < 80) {FETCH, DECODE, EXECUTE, COMMIT} = 4'b0000;
      else             {FETCH, DECODE, EXECUTE, COMMIT} = 4'($urandom_range(0, 15));
      model_step();
      @(posedge CLK); #1;
      n_tests++; if (BUNDLE !== m_bundle) begin n_fail++; $display("FAIL rnd_bundle cyc %0d got %h want %h", i, BUNDLE, m_bundle); end
      n_tests++; if (BUNDLE_VALID !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, BUNDLE_VALID, m_valid); end
      n_tests++; if (GROUP !== m_group) begin n_fail++; $display("FAIL rnd_group cyc %0d got %0d want %0d", i, GROUP, m_group); end
      n_tests++; if (ADDR_BUSX !== m_addr) begin n_fail++; $display("FAIL rnd_addrx cyc %0d got %0d want %0d", i, ADDR_BUSX, m_addr); end
      n_tests++; if (PHASE_ERR !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b want %b", i, PHASE_ERR, m_err); end
    end
    RESET = 1'b0; STALL = 1'b0;
    {FETCH, DECODE, EXECUTE, COMMIT} = 4'b0000;
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; INSTRUCTION = 16'h0;
    {FETCH, DECODE, EXECUTE, COMMIT} = 4'b0000;
    m_ph = 0; m_group = '0; m_bundle = DEF; m_valid = 1'b0; m_addr = PCA; m_err = 1'b0;
    set_default_src();
    test_reset();
    test_reset_mid_execute();
    test_sequence();
    test_invalid_group();
    test_stall();
    test_fetch_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
